// File: rtl/mux_pkg.sv
// Shared types and helpers for the MUX8 serializer controller and its selector.
package mux_pkg;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Select index for the first bit of a word.
    function automatic logic [SEL_W-1:0] first_sel(input logic lsb_first);
        return lsb_first ? SEL_W'(0) : SEL_W'(WORD_W - 1);
    endfunction

    // Step the select one position in the shift direction.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel,
                                                 input logic            lsb_first);
        return lsb_first ? sel + SEL_W'(1) : sel - SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux8.sv
// MUX8 8:1 bit selector driven by the serializer controller.
module mux8
    import mux_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [SEL_W-1:0]  s,
    output logic              out
);

    assign out = in[s];

endmodule

// File: rtl/mux8_serializer_ctrl.sv
// Holds a byte on the MUX8 inputs, walks the select through all eight positions
// and registers the selected bit as a serial stream with valid/last flags.
module mux8_serializer_ctrl
    import mux_pkg::*;
#(
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned DIV       = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              abort,
    output logic [WORD_W-1:0] mux_in,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_out,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int unsigned      DIV_W    = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SEL_W-1:0] LAST_BIT = SEL_W'(WORD_W - 1);

    state_t            state, state_d;
    logic [WORD_W-1:0] mux_in_d;
    logic [SEL_W-1:0]  mux_sel_d;
    logic [SEL_W-1:0]  bit_cnt, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt, div_cnt_d;
    logic              ser_bit_d, ser_valid_d, ser_last_d, busy_d;
    logic              tick, word_end, accept;

    // Bit-end tick and the back-to-back acceptance window it opens on the last bit.
    assign tick       = (state == ST_SHIFT) && (div_cnt == DIV_LAST);
    assign word_end   = tick && (bit_cnt == LAST_BIT);
    assign load_ready = !abort && ((state == ST_IDLE) || word_end);
    assign accept     = load_ready && load_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mux_in    <= '0;
            mux_sel   <= first_sel(LSB_FIRST);
            bit_cnt   <= '0;
            div_cnt   <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            mux_in    <= mux_in_d;
            mux_sel   <= mux_sel_d;
            bit_cnt   <= bit_cnt_d;
            div_cnt   <= div_cnt_d;
            ser_bit   <= ser_bit_d;
            ser_valid <= ser_valid_d;
            ser_last  <= ser_last_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state;
        mux_in_d    = mux_in;
        mux_sel_d   = mux_sel;
        bit_cnt_d   = bit_cnt;
        div_cnt_d   = div_cnt;
        ser_bit_d   = ser_bit;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;

        case (state)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                // Abort suppresses the tick sample and any reload in the same cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                    if (tick) begin
                        ser_bit_d   = mux_out;
                        ser_valid_d = 1'b1;
                        ser_last_d  = word_end;
                        div_cnt_d   = '0;
                        bit_cnt_d   = bit_cnt + SEL_W'(1);
                        if (word_end) begin
                            state_d = ST_IDLE;
                        end else begin
                            mux_sel_d = next_sel(mux_sel, LSB_FIRST);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d   = ST_SHIFT;
            mux_in_d  = load_data;
            mux_sel_d = first_sel(LSB_FIRST);
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end

        busy_d = (state_d == ST_SHIFT);
    end

endmodule

// File: tb/tb_mux8_serializer_ctrl.sv
// Bench for mux8_serializer_ctrl: three configurations each paired with a MUX8,
// checked cycle by cycle against an event-table model of the serial stream.
module tb_mux8_serializer_ctrl;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] load_data  [NI];
    logic       load_valid [NI];
    logic       abort      [NI];
    logic       load_ready [NI];
    logic [7:0] mux_in     [NI];
    logic [2:0] mux_sel    [NI];
    logic       mux_out    [NI];
    logic       ser_bit    [NI];
    logic       ser_valid  [NI];
    logic       ser_last   [NI];
    logic       busy       [NI];

    int n_cmp = 0;
    int n_bad = 0;

    // Expected stream indexed by cycle offset from the first accept.
    bit exp_v [128];
    bit exp_b [128];
    bit exp_l [128];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned GDIV = (g == 2) ? 3 : 1;
        localparam bit          GLSB = (g != 1);
        mux8_serializer_ctrl #(.LSB_FIRST(GLSB), .DIV(GDIV)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_data (load_data[g]),
            .load_valid(load_valid[g]),
            .load_ready(load_ready[g]),
            .abort     (abort[g]),
            .mux_in    (mux_in[g]),
            .mux_sel   (mux_sel[g]),
            .mux_out   (mux_out[g]),
            .ser_bit   (ser_bit[g]),
            .ser_valid (ser_valid[g]),
            .ser_last  (ser_last[g]),
            .busy      (busy[g])
        );
        mux8 u_mux (
            .in (mux_in[g]),
            .s  (mux_sel[g]),
            .out(mux_out[g])
        );
    end

    function automatic int div_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic bit lsb_of(input int i);
        return (i != 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int i, input int o,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, i, o, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int o = 0; o < 128; o++) begin
            exp_v[o] = 1'b0;
            exp_b[o] = 1'b0;
            exp_l[o] = 1'b0;
        end
    endtask

    // Word accepted at offset t: bit k appears at t+1+div*(k+1); entries past cut are dropped.
    task automatic add_word(input int t, input logic [7:0] w, input int div,
                            input bit lsb, input int cut);
        int o;
        for (int k = 0; k < 8; k++) begin
            o = t + 1 + div * (k + 1);
            if (o <= cut) begin
                exp_v[o] = 1'b1;
                exp_b[o] = lsb ? w[k] : w[7-k];
                exp_l[o] = (k == 7);
            end
        end
    endtask

    task automatic sample(input int i, input int o);
        check("ser_valid", i, o, 32'(ser_valid[i]), 32'(exp_v[o]));
        check("ser_last", i, o, 32'(ser_last[i]), 32'(exp_l[o]));
        if (exp_v[o])
            check("ser_bit", i, o, 32'(ser_bit[i]), 32'(exp_b[o]));
    endtask

    task automatic check_reset(input int i);
        check("rst_ser_bit", i, 0, 32'(ser_bit[i]), 32'(0));
        check("rst_ser_valid", i, 0, 32'(ser_valid[i]), 32'(0));
        check("rst_ser_last", i, 0, 32'(ser_last[i]), 32'(0));
        check("rst_busy", i, 0, 32'(busy[i]), 32'(0));
        check("rst_mux_in", i, 0, 32'(mux_in[i]), 32'(0));
        check("rst_mux_sel", i, 0, 32'(mux_sel[i]), lsb_of(i) ? 32'(0) : 32'(7));
        check("rst_load_ready", i, 0, 32'(load_ready[i]), 32'(1));
    endtask

    task automatic word_test(input int i, input logic [7:0] w);
        int div;
        bit lsb;
        int k;
        div = div_of(i);
        lsb = lsb_of(i);
        clear_model();
        add_word(0, w, div, lsb, 1000);
        check("idle_ready", i, 0, 32'(load_ready[i]), 32'(1));
        check("idle_busy", i, 0, 32'(busy[i]), 32'(0));
        load_valid[i] = 1'b1;
        load_data[i]  = w;
        step();
        load_valid[i] = 1'b0;
        load_data[i]  = 8'($urandom);
        for (int o = 1; o <= 8 * div + 2; o++) begin
            sample(i, o);
            check("busy", i, o, 32'(busy[i]), 32'(o <= 8 * div));
            check("load_ready", i, o, 32'(load_ready[i]), 32'(o >= 8 * div));
            check("mux_in", i, o, 32'(mux_in[i]), 32'(w));
            if (o <= 8 * div) begin
                k = (o - 1) / div;
                check("mux_sel", i, o, 32'(mux_sel[i]), lsb ? 32'(k) : 32'(7 - k));
            end
            step();
        end
    endtask

    task automatic b2b_test(input int i, input logic [7:0] w0, input logic [7:0] w1);
        int div;
        bit lsb;
        div = div_of(i);
        lsb = lsb_of(i);
        clear_model();
        add_word(0, w0, div, lsb, 1000);
        load_valid[i] = 1'b1;
        load_data[i]  = w0;
        step();
        load_data[i] = w1;
        for (int o = 1; o <= 16 * div + 2; o++) begin
            sample(i, o);
            check("b2b_ready", i, o, 32'(load_ready[i]), 32'((o == 8 * div) || (o >= 16 * div)));
            check("b2b_busy", i, o, 32'(busy[i]), 32'(o <= 16 * div));
            check("b2b_mux_in", i, o, 32'(mux_in[i]), (o <= 8 * div) ? 32'(w0) : 32'(w1));
            if (o == 8 * div)
                add_word(8 * div, w1, div, lsb, 1000);
            step();
            if (o == 8 * div)
                load_valid[i] = 1'b0;
        end
    endtask

    // Abort held high for exactly cycle ab of the word.
    task automatic abort_test(input int i, input logic [7:0] w, input int ab);
        int div;
        div = div_of(i);
        clear_model();
        add_word(0, w, div, lsb_of(i), ab);
        load_valid[i] = 1'b1;
        load_data[i]  = w;
        step();
        load_valid[i] = 1'b0;
        for (int o = 1; o <= 8 * div + 2; o++) begin
            abort[i] = (o == ab);
            #1;
            sample(i, o);
            check("abort_ready", i, o, 32'(load_ready[i]), 32'(o > ab));
            check("abort_busy", i, o, 32'(busy[i]), 32'(o <= ab));
            check("abort_mux_in", i, o, 32'(mux_in[i]), 32'(w));
            step();
        end
        abort[i] = 1'b0;
    endtask

    task automatic idle_abort_test(input int i);
        load_valid[i] = 1'b1;
        load_data[i]  = 8'($urandom);
        abort[i]      = 1'b1;
        #1;
        check("idle_abort_ready", i, 0, 32'(load_ready[i]), 32'(0));
        step();
        check("idle_abort_busy", i, 1, 32'(busy[i]), 32'(0));
        check("idle_abort_valid", i, 1, 32'(ser_valid[i]), 32'(0));
        load_valid[i] = 1'b0;
        abort[i]      = 1'b0;
        #1;
        check("idle_abort_release", i, 1, 32'(load_ready[i]), 32'(1));
        step();
    endtask

    task automatic reset_test(input int i, input logic [7:0] w);
        int div;
        div = div_of(i);
        clear_model();
        add_word(0, w, div, lsb_of(i), 1000);
        load_valid[i] = 1'b1;
        load_data[i]  = w;
        step();
        load_valid[i] = 1'b0;
        for (int o = 1; o <= 1 + 4 * div; o++) begin
            sample(i, o);
            if (o < 1 + 4 * div)
                step();
        end
        rst_n = 1'b0;
        #1;
        check_reset(i);
        step();
        check_reset(i);
        rst_n = 1'b1;
        step();
        check("post_rst_valid", i, 0, 32'(ser_valid[i]), 32'(0));
        check("post_rst_busy", i, 0, 32'(busy[i]), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            load_valid[i] = 1'b0;
            load_data[i]  = 8'h00;
            abort[i]      = 1'b0;
        end
        rst_n = 1'b0;
        step();
        step();
        for (int i = 0; i < NI; i++)
            check_reset(i);
        rst_n = 1'b1;
        step();

        word_test(0, 8'hA5);
        word_test(1, 8'hC8);
        word_test(2, 8'h06);
        b2b_test(0, 8'h0C, 8'h40);
        abort_test(0, 8'hD0, 1 + 3 * div_of(0));
        word_test(0, 8'h07);
        idle_abort_test(0);
        reset_test(0, 8'hA1);
        word_test(0, 8'h01);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NI; i++) begin
                word_test(i, 8'($urandom));
                b2b_test(i, 8'($urandom), 8'($urandom));
                abort_test(i, 8'($urandom), int'($urandom_range(8 * div_of(i), 1)));
            end
        end
        abort_test(2, 8'hFF, 8 * div_of(2));
        word_test(2, 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
